// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline memory stage: datapath widths and the
// EX/MEM and MEM/WB pipeline register records.
package pipe_pkg;

    localparam int XLEN = 32;   // data word width
    localparam int RW   = 5;    // register-number width

    // Contents of the EX/MEM pipeline register.
    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic [RW-1:0]   wn;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] qb;
    } exmem_t;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic            wreg;
        logic [RW-1:0]   wn;
        logic [XLEN-1:0] data;
    } memwb_t;

endpackage

// File: rtl/pipe_dmem.sv
// Word-addressed data memory. Read is combinational so a load resolves in the
// same cycle it sits in MEM; writes land on the rising edge. Contents are
// never reset.
module pipe_dmem
    import pipe_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Single write port; the address is already reduced modulo DEPTH.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage of a classic 5-stage pipeline: EX/MEM register, data memory and
// MEM/WB register. Optional misaligned-access trap is compiled in with the
// macro PIPE_MEM_MISALIGN_TRAP_EN.
module pipe_mem_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    input  logic            EXwreg,
    input  logic            EXm2reg,
    input  logic            EXwmem,
    input  logic [RW-1:0]   EXwn,
    input  logic [XLEN-1:0] EXaluResult,
    input  logic [XLEN-1:0] EXqb,
    output logic            MEMwreg,
    output logic            MEMm2reg,
    output logic [RW-1:0]   MEMwn,
    output logic [XLEN-1:0] MEMaluResult,
    output logic            WBwreg,
    output logic [RW-1:0]   WBwn,
    output logic [XLEN-1:0] WBdata,
    output logic            misalign_err
);

    exmem_t          exmem_reg;
    exmem_t          exmem_next;
    memwb_t          memwb_reg;
    memwb_t          memwb_next;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            misalign;
    logic            mem_we;

    // Word index: byte-offset bits and everything above the memory size drop
    // out, which gives wrap-around modulo DEPTH for free.
    assign mem_addr = exmem_reg.alu[AW+1:2];

`ifdef PIPE_MEM_MISALIGN_TRAP_EN
    assign misalign = (exmem_reg.wmem || exmem_reg.m2reg) && (exmem_reg.alu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A store commits only in an unstalled, non-cleared cycle, so a stalled
    // store fires exactly once when the stall lifts.
    assign mem_we = exmem_reg.wmem && !stall && !clr && !misalign;

    pipe_dmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (exmem_reg.qb),
        .rdata (mem_rdata)
    );

    // Next-state values for both pipeline registers. The memory read here is
    // the pre-write value, so a combined store+load forwards the old word.
    always_comb begin
        exmem_next       = '{wreg: EXwreg, m2reg: EXm2reg, wmem: EXwmem,
                             wn: EXwn, alu: EXaluResult, qb: EXqb};
        memwb_next.wreg  = exmem_reg.wreg && !misalign;
        memwb_next.wn    = exmem_reg.wn;
        memwb_next.data  = exmem_reg.m2reg ? mem_rdata : exmem_reg.alu;
    end

    // Both pipeline registers share one enable; clear wins over stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            exmem_reg <= '0;
            memwb_reg <= '0;
        end else if (!stall) begin
            exmem_reg <= exmem_next;
            memwb_reg <= memwb_next;
        end
    end

`ifdef PIPE_MEM_MISALIGN_TRAP_EN
    logic err_reg;

    // Sticky error flag, set when a misaligned access executes, cleared by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            err_reg <= 1'b0;
        end else if (!stall && misalign) begin
            err_reg <= 1'b1;
        end
    end

    assign misalign_err = err_reg;
`else
    assign misalign_err = 1'b0;
`endif

    assign MEMwreg      = exmem_reg.wreg;
    assign MEMm2reg     = exmem_reg.m2reg;
    assign MEMwn        = exmem_reg.wn;
    assign MEMaluResult = exmem_reg.alu;
    assign WBwreg       = memwb_reg.wreg;
    assign WBwn         = memwb_reg.wn;
    assign WBdata       = memwb_reg.data;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_pipe_mem_stage;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        clr, stall;
    logic        ex_wreg, ex_m2reg, ex_wmem;
    logic [4:0]  ex_wn;
    logic [31:0] ex_alu, ex_qb;
    logic        MEMwreg, MEMm2reg, WBwreg, misalign_err;
    logic [4:0]  MEMwn, WBwn;
    logic [31:0] MEMaluResult, WBdata;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction now in MEM, the last retired result,
    // the memory image and the sticky error flag.
    logic        m_wreg, m_m2reg, m_wmem;
    logic [4:0]  m_wn;
    logic [31:0] m_alu, m_qb;
    logic        w_wreg;
    logic [4:0]  w_wn;
    logic [31:0] w_data;
    logic [31:0] model_mem [DEPTH];
    logic        model_err;

    always #5 clk = ~clk;

    pipe_mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .clr          (clr),
        .stall        (stall),
        .EXwreg       (ex_wreg),
        .EXm2reg      (ex_m2reg),
        .EXwmem       (ex_wmem),
        .EXwn         (ex_wn),
        .EXaluResult  (ex_alu),
        .EXqb         (ex_qb),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .WBwreg       (WBwreg),
        .WBwn         (WBwn),
        .WBdata       (WBdata),
        .misalign_err (misalign_err)
    );

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr / 4) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic wr, input logic m2, input logic wm,
                          input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] qb);
        ex_wreg = wr; ex_m2reg = m2; ex_wmem = wm; ex_wn = wn; ex_alu = alu; ex_qb = qb;
    endtask

    // One clock edge; the model retires the instruction in MEM and accepts
    // the one presented by EX, then outputs are sampled 1 time unit later.
    task automatic tick();
        int   idx;
        logic mis;
        @(posedge clk);
        if (clr) begin
            {m_wreg, m_m2reg, m_wmem, m_wn, m_alu, m_qb} = '0;
            {w_wreg, w_wn, w_data} = '0;
            model_err = 1'b0;
        end else if (!stall) begin
            idx = word_of(m_alu);
            mis = 1'b0;
`ifdef PIPE_MEM_MISALIGN_TRAP_EN
            mis = (m_wmem || m_m2reg) && (m_alu % 4 != 0);
`endif
            w_wreg = m_wreg && !mis;
            w_wn   = m_wn;
            w_data = m_m2reg ? model_mem[idx] : m_alu;
            if (m_wmem && !mis) model_mem[idx] = m_qb;
            if (mis) model_err = 1'b1;
            m_wreg = ex_wreg; m_m2reg = ex_m2reg; m_wmem = ex_wmem;
            m_wn = ex_wn; m_alu = ex_alu; m_qb = ex_qb;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".MEMwreg"},      {31'd0, MEMwreg},  {31'd0, m_wreg});
        chk({tag, ".MEMm2reg"},     {31'd0, MEMm2reg}, {31'd0, m_m2reg});
        chk({tag, ".MEMwn"},        {27'd0, MEMwn},    {27'd0, m_wn});
        chk({tag, ".MEMaluResult"}, MEMaluResult,      m_alu);
        chk({tag, ".WBwreg"},       {31'd0, WBwreg},   {31'd0, w_wreg});
        chk({tag, ".WBwn"},         {27'd0, WBwn},     {27'd0, w_wn});
        chk({tag, ".WBdata"},       WBdata,            w_data);
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, model_err});
    endtask

    initial begin
        logic [31:0] r;
        clr = 1'b1; stall = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0);
        model_err = 1'b0;

        // Reset held for two edges: everything reads zero.
        tick(); tick();
        clr = 1'b0;
        chk("rst.MEMwreg", {31'd0, MEMwreg}, 32'd0);
        chk("rst.MEMm2reg", {31'd0, MEMm2reg}, 32'd0);
        chk("rst.MEMwn", {27'd0, MEMwn}, 32'd0);
        chk("rst.MEMaluResult", MEMaluResult, 32'd0);
        chk("rst.WBwreg", {31'd0, WBwreg}, 32'd0);
        chk("rst.WBwn", {27'd0, WBwn}, 32'd0);
        chk("rst.WBdata", WBdata, 32'd0);
        chk("rst.misalign_err", {31'd0, misalign_err}, 32'd0);

        // Fill every word with known data through ordinary stores.
        for (int i = 0; i < DEPTH; i++) begin
            set_ex(0, 0, 1, 0, 32'(i * 4), $urandom);
            tick();
        end
        set_ex(0, 0, 0, 0, 0, 0);
        tick();
        $display("preload done");

        // Store then immediately load the same word.
        set_ex(0, 0, 1, 0, 32'h10, 32'hDEADBEEF); tick();
        set_ex(1, 1, 0, 5, 32'h10, 0);            tick();
        set_ex(0, 0, 0, 0, 0, 0);                 tick();
        chk("st_ld.WBwreg", {31'd0, WBwreg}, 32'd1);
        chk("st_ld.WBwn", {27'd0, WBwn}, 32'd5);
        chk("st_ld.WBdata", WBdata, 32'hDEADBEEF);
        $display("store/load 0x10 WBdata=%h", WBdata);

        // ALU pass-through latency.
        set_ex(1, 0, 0, 3, 32'h1234, 0); tick();
        chk("alu.MEMaluResult", MEMaluResult, 32'h1234);
        set_ex(0, 0, 0, 0, 0, 0);        tick();
        chk("alu.WBdata", WBdata, 32'h1234);
        chk("alu.WBwn", {27'd0, WBwn}, 32'd3);
        $display("alu op WBdata=%h WBwn=%0d", WBdata, WBwn);

        // Stalled store: memory is clobbered between stalled edges and must
        // be written exactly once, at release.
        set_ex(0, 0, 1, 0, 32'h20, 32'h55); tick();
        stall = 1'b1;
        set_ex(1, 0, 0, 9, 32'hABCD, 0);
        for (int i = 0; i < 3; i++) begin
            dut.u_dmem.mem[8] = 32'hAAAA_0000 + 32'(i);
            model_mem[8] = 32'hAAAA_0000 + 32'(i);
            tick();
            chk("stall.nowrite", dut.u_dmem.mem[8], 32'hAAAA_0000 + 32'(i));
            check_all("stall");
        end
        stall = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0);
        tick();
        chk("stall.release_write", dut.u_dmem.mem[8], 32'h55);
        dut.u_dmem.mem[8] = 32'h77; model_mem[8] = 32'h77;
        tick();
        chk("stall.single_write", dut.u_dmem.mem[8], 32'h77);
        dut.u_dmem.mem[8] = 32'h55; model_mem[8] = 32'h55;
        set_ex(1, 1, 0, 4, 32'h20, 0); tick();
        set_ex(0, 0, 0, 0, 0, 0);      tick();
        chk("stall.load", WBdata, 32'h55);
        $display("stalled store load WBdata=%h", WBdata);

        // Misaligned store to 0x22 followed by a load of the same address.
        r = dut.u_dmem.mem[8];
        set_ex(0, 0, 1, 0, 32'h22, 32'hC0FFEE00); tick();
        set_ex(1, 1, 0, 6, 32'h22, 0);            tick();
        set_ex(0, 0, 0, 0, 0, 0);                 tick();
`ifdef PIPE_MEM_MISALIGN_TRAP_EN
        chk("mis.mem_unchanged", dut.u_dmem.mem[8], r);
        chk("mis.err", {31'd0, misalign_err}, 32'd1);
        chk("mis.WBwreg", {31'd0, WBwreg}, 32'd0);
        tick();
        chk("mis.err_sticky", {31'd0, misalign_err}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("mis.err_clr", {31'd0, misalign_err}, 32'd0);
`else
        chk("mis.mem_written", dut.u_dmem.mem[8], 32'hC0FFEE00);
        chk("mis.WBdata", WBdata, 32'hC0FFEE00);
        chk("mis.err", {31'd0, misalign_err}, 32'd0);
`endif
        $display("misaligned 0x22 err=%0b WBwreg=%0b", misalign_err, WBwreg);

        // Address wrap: 0x100 maps to word 0.
        set_ex(0, 0, 1, 0, 32'h0, 32'h0BADF00D); tick();
        set_ex(1, 1, 0, 7, 32'h100, 0);          tick();
        set_ex(0, 0, 0, 0, 0, 0);                tick();
        chk("wrap.WBdata", WBdata, 32'h0BADF00D);
        $display("wrap load 0x100 WBdata=%h", WBdata);

        // Clear beats stall and suppresses the store sitting in MEM.
        set_ex(1, 0, 1, 2, 32'h40, 32'h12345678); tick();
        r = dut.u_dmem.mem[16];
        clr = 1'b1; stall = 1'b1; tick();
        clr = 1'b0; stall = 1'b0;
        chk("clr.store_suppressed", dut.u_dmem.mem[16], r);
        chk("clr.MEMaluResult", MEMaluResult, 32'd0);
        chk("clr.MEMwreg", {31'd0, MEMwreg}, 32'd0);
        $display("clr over stall MEMaluResult=%h", MEMaluResult);

        // Randomized traffic against the model.
        set_ex(0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
`ifdef PIPE_MEM_MISALIGN_TRAP_EN
            if ($urandom_range(9) != 0) a = a & ~32'd3;
`endif
            set_ex(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom);
            stall = ($urandom_range(4) == 0);
            clr   = ($urandom_range(49) == 0);
            tick();
            check_all("rand");
            $display("rand %0d clr=%0b stall=%0b MEMalu=%h WBwreg=%0b WBwn=%0d WBdata=%h",
                     i, clr, stall, MEMaluResult, WBwreg, WBwn, WBdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter DEPTH, default 64: data memory depth in 32-bit words, power of two, 4..1024.
REQ-002 Parameter AW, default 6: word-address width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  freezes the MEM stage for the current cycle.
REQ-006 EXwreg  input  1  register-write enable from EX.
REQ-007 EXm2reg  input  1  load select from EX (1 selects memory data for write-back).
REQ-008 EXwmem  input  1  store enable from EX.
REQ-009 EXwn  input  5  destination register number from EX.
REQ-010 EXaluResult  input  32  ALU result or byte address from EX.
REQ-011 EXqb  input  32  store data from EX.
REQ-012 MEMwreg, MEMm2reg  output  1 each  EX/MEM register contents.
REQ-013 MEMwn  output  5  EX/MEM destination register.
REQ-014 MEMaluResult  output  32  EX/MEM ALU result; this is the forwarding source for EX.
REQ-015 WBwreg  output  1  MEM/WB write enable to the register file.
REQ-016 WBwn  output  5  MEM/WB destination register.
REQ-017 WBdata  output  32  MEM/WB write-back data; this is the forwarding source for EX.
REQ-018 misalign_err  output  1  sticky misaligned-access flag (see Configuration).

Function
REQ-019 The EX/MEM register SHALL capture all EX* inputs on each rising edge where clr=0 and stall=0.
REQ-020 The memory word address SHALL be MEMaluResult[AW+1:2]; bits [1:0] and bits above AW+1 are ignored for indexing.
REQ-021 Memory read SHALL be combinational from the current EX/MEM contents.
REQ-022 Memory SHALL write MEMqb (EX/MEM copy of EXqb) at the rising edge that ends a cycle with MEMwmem=1, stall=0 and clr=0.
REQ-023 The MEM/WB register SHALL capture on the same enable as the EX/MEM register: WBwreg<=MEMwreg, WBwn<=MEMwn, WBdata<=(MEMm2reg ? memory read : MEMaluResult).
REQ-024 Latency SHALL be 1 clock from EX inputs to MEM* outputs and 2 clocks from EX inputs to WB* outputs.
REQ-025 While stall=1, both registers SHALL hold, and no memory write SHALL occur; a store SHALL execute exactly once, in its first unstalled MEM cycle.
REQ-026 A load that directly follows a store to the same word SHALL return the newly stored data.
REQ-027 A combined wmem=1 and m2reg=1 SHALL perform the write and forward the pre-write read data to WB.
REQ-028 An address beyond DEPTH words SHALL wrap modulo DEPTH.

Reset
REQ-029 With clr=1 at a rising edge, all outputs SHALL become 0 and misalign_err SHALL clear; clr takes priority over stall.
REQ-030 A store in MEM during a clr cycle SHALL be suppressed.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 Macro PIPE_MEM_MISALIGN_TRAP_EN:
- Defined: if MEMwmem or MEMm2reg is 1 and MEMaluResult[1:0]!=0, the store is suppressed, the captured WBwreg is forced to 0, and misalign_err is set and held until clr.
- Undefined: bits [1:0] are ignored and misalign_err is tied to 0.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the word width of 32, the register-number width of 5, and the EX/MEM and MEM/WB record typedefs.
REQ-034 Data memory SHALL be the sub-module pipe_dmem (parameters DEPTH and AW; ports clk, we, addr, wdata, rdata).

Verification
REQ-035 clr=1 for 2 cycles, then release -> all outputs are 0 and misalign_err=0.
REQ-036 Store 0xDEADBEEF to address 0x10, then load from 0x10 in the next cycle with wreg=1 and wn=5 -> two cycles after the load input: WBwreg=1, WBwn=5, WBdata=0xDEADBEEF.
REQ-037 ALU op with aluResult=0x1234, m2reg=0, wn=3 -> MEMaluResult=0x1234 after 1 clock; WBdata=0x1234 and WBwn=3 after 2 clocks.
REQ-038 Store 0x55 to address 0x20 with stall=1 for 3 cycles, then stall=0, and clobber memory via the bench between stalled edges -> exactly one write occurs, after release, and a later load returns 0x55.
REQ-039 Macro defined: store to 0x22 -> memory is unchanged, misalign_err=1 until clr, and a load of 0x22 gives WBwreg=0. Macro undefined: the same store writes word 8.
REQ-040 Load from 0x100 with DEPTH=64 -> returns the contents of word 0.
